kmeans_centroid_update: RTL and testbench
=========================================

# kmeans_centroid_update

Downstream stage of the Manhattan-distance / minimum-select classifier in the colour-quantisation pipeline. Per frame, it accumulates each classified pixel into one of 8 cluster accumulators, keyed by the winning index. On frame end it computes each cluster's mean colour with a sequential divider. It then streams the 8 new centroids out in index order, so the controller can reload the classifier's centroid registers (`c_in0..c_in7`, loaded with `c_en`).

## Interface
Parameters:
- `CNT_W`, default 12: per-cluster pixel-count width. Maximum 2^CNT_W−1 pixels per cluster per frame.
- `SUM_W`, derived localparam = `CNT_W`+8: per-channel sum width, also the divider iteration count.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `clear`, input, 1: synchronous abort. Zeroes accumulators and returns the block to ACCUM.
- `pix_valid`, input, 1: `pix_in`/`pix_index` valid this cycle.
- `pix_ready`, output, 1: block accepts pixels. Equals ~busy.
- `pix_in`, input, 24: pixel, R[23:16], G[15:8], B[7:0].
- `pix_index`, input, 3: cluster index from the minimum selector (`out_index`).
- `frame_end`, input, 1: one-cycle pulse marking the last pixel of the frame.
- `c_valid`, output, 1: one-cycle pulse; `c_idx`/`c_out`/`c_empty` are valid.
- `c_idx`, output, 3: cluster index of the emitted centroid.
- `c_out`, output, 24: new centroid, per-channel floor(sum/count), same packing as `pix_in`.
- `c_empty`, output, 1: cluster received 0 pixels; `c_out`=0; consumer keeps the old centroid.
- `busy`, output, 1: division/emit sequence in progress.
- `done`, output, 1: one-cycle pulse, coincident with the cluster-7 `c_valid`.
- `ovf`, output, 1: sticky. A pixel was dropped because a cluster count saturated.

## Operation
- Storage: 8 × (three `SUM_W` sums + one `CNT_W` count).
- FSM states: ACCUM, LOAD, ITER, EMIT.
- ACCUM:
  - Accept a pixel when `pix_valid`&`pix_ready`.
  - Add R/G/B to `sum[pix_index]` and increment `cnt[pix_index]`.
  - If `cnt[pix_index]`=2^CNT_W−1, drop the pixel (sums and count unchanged) and set `ovf`.
- `frame_end` sampled in ACCUM:
  - Any pixel accepted in the same cycle is included.
  - Set k=0 and go to LOAD.
- LOAD: latch `sum[k]` (3 channels) and `cnt[k]` into the divider. If `cnt[k]`=0, the divider is bypassed in effect: the result is forced to 0 and `c_empty`=1.
- ITER: `SUM_W` cycles. Three parallel restoring dividers, one quotient bit per cycle, MSB first. Quotients are ≤255 by construction; the low 8 bits are used.
- EMIT:
  - Assert `c_valid` with `c_idx`=k.
  - If k<7: k++ and go to LOAD.
  - If k=7: pulse `done`, zero all sums/counts at the end of this cycle, go to ACCUM.
- `pix_valid` while `busy`: ignored. No pixel is stored; upstream must stall on `pix_ready`=0.
- `frame_end` while `busy`: ignored.
- `clear`:
  - Zeroes sums, counts, k and `ovf`, and returns to ACCUM.
  - Aborts any division in progress; no further `c_valid`/`done` for that frame.
  - `clear` wins over a simultaneous `pix_valid`/`frame_end`.
- `rst` low, any time: same effect as `clear`, asynchronously.
- Reset values: `pix_ready`=1, `busy`=0, `c_valid`=0, `c_idx`=0, `c_out`=0, `c_empty`=0, `done`=0, `ovf`=0. State ACCUM; all accumulators 0.

## Timing
- Pixel accumulation: one pixel per cycle, back-to-back, zero bubbles in ACCUM.
- Let cycle 0 be the cycle after the edge that samples `frame_end`.
- Cluster k:
  - LOAD in cycle k·(SUM_W+2).
  - ITER in cycles k·(SUM_W+2)+1 … k·(SUM_W+2)+SUM_W.
  - EMIT (`c_valid`) in cycle k·(SUM_W+2)+SUM_W+1.
- With defaults: `c_valid` in cycles 21, 43, …, 175; `done` in cycle 175.
- `busy`=1 and `pix_ready`=0 in cycles 0…8·(SUM_W+2)−1. First new pixel is accepted in cycle 176.
- All outputs are registered. `c_out`/`c_idx`/`c_empty` are meaningful only while `c_valid`=1; they hold their last value otherwise.

## Test plan
- Reset:
  - Stimulus: assert `rst`=0 mid-ITER of cluster 3.
  - Required: all outputs take reset values immediately; no `c_valid` afterwards. A following frame with cluster 0 = {0x102030} emits `c_out`=0x102030 in cycle 21.
- Basic mean:
  - Stimulus: pixels 0x0A1420 and 0x0C1622 with index 2, then `frame_end`.
  - Required: cycle 65 `c_idx`=2, `c_out`=0x0B1521, `c_empty`=0. The other 7 clusters emit `c_empty`=1, `c_out`=0. `done` in cycle 175.
- Floor rounding plus same-cycle `frame_end`:
  - Stimulus: index 5 pixels 0x000001, then 0x000002 with `frame_end` high in the same cycle.
  - Required: cluster 5 `c_out`=0x000001, count 2.
- Busy lockout:
  - Stimulus: `pix_valid` with index 0 pixel 0xFFFFFF during cycles 10–30.
  - Required: `pix_ready`=0; next frame's cluster 0 result excludes that pixel.
- `clear` mid-division:
  - Stimulus: `clear` in cycle 40.
  - Required: no `c_valid` for k≥1 and no `done`. Next frame containing only index 1 = 0x808080 yields 0x808080 with all other clusters empty.
- Saturation, `CNT_W`=4:
  - Stimulus: 17 pixels 0xFFFFFF to index 0.
  - Required: `ovf`=1 after the 16th; cluster 0 `c_out`=0xFFFFFF; `ovf` cleared by `clear`.

Source files
------------

// File: rtl/kmeans_centroid_update.sv
// kmeans_centroid_update
// Per-frame cluster accumulator and mean calculator for the colour-quantisation
// pipeline. Pixels are summed per winning cluster index. On frame end each
// cluster's mean colour is computed with three parallel restoring dividers and
// streamed out in index order.
module kmeans_centroid_update #(
    parameter int CNT_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_in,
    input  logic [2:0]  pix_index,
    input  logic        frame_end,
    output logic        c_valid,
    output logic [2:0]  c_idx,
    output logic [23:0] c_out,
    output logic        c_empty,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    localparam int SUM_W = CNT_W + 8;
    localparam int ITW   = $clog2(SUM_W);

    typedef enum logic [1:0] {
        ACCUM,
        LOAD,
        ITER,
        EMIT
    } state_t;

    state_t state;

    // Accumulators; channel 0 = B, 1 = G, 2 = R (matches pix_in[8*c +: 8])
    logic [SUM_W-1:0] sum_q [8][3];
    logic [CNT_W-1:0] cnt_q [8];

    logic [2:0]       k;

    // Divider datapath: shared divisor, one dividend/remainder/quotient per channel
    logic [SUM_W-1:0] dvd [3];
    logic [CNT_W-1:0] rem [3];
    logic [6:0]       quo [3];
    logic [CNT_W-1:0] dvs;
    logic             zero_div;
    logic [ITW-1:0]   it_cnt;

    logic [CNT_W:0]   trial  [3];
    logic [CNT_W:0]   diff   [3];
    logic             ge     [3];
    logic [CNT_W-1:0] rem_nx [3];
    logic [7:0]       quo_nx [3];

    // One restoring-division step per channel: shift in the next dividend bit,
    // subtract the divisor when it fits (borrow bit of the difference decides).
    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            trial[c]  = {rem[c], dvd[c][SUM_W-1]};
            diff[c]   = trial[c] - {1'b0, dvs};
            ge[c]     = ~diff[c][CNT_W];
            rem_nx[c] = ge[c] ? diff[c][CNT_W-1:0] : trial[c][CNT_W-1:0];
            quo_nx[c] = {quo[c], ge[c]};
        end
    end

    // Control FSM, accumulator update, divider sequencing and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ACCUM;
            k         <= '0;
            dvs       <= '0;
            zero_div  <= 1'b0;
            it_cnt    <= '0;
            pix_ready <= 1'b1;
            busy      <= 1'b0;
            c_valid   <= 1'b0;
            c_idx     <= '0;
            c_out     <= '0;
            c_empty   <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
                for (int unsigned c = 0; c < 3; c++) begin
                    sum_q[i][c] <= '0;
                end
            end
            for (int unsigned c = 0; c < 3; c++) begin
                dvd[c] <= '0;
                rem[c] <= '0;
                quo[c] <= '0;
            end
        end else if (clear) begin
            // Abort: drop the frame and any division in flight
            state     <= ACCUM;
            k         <= '0;
            pix_ready <= 1'b1;
            busy      <= 1'b0;
            c_valid   <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
                for (int unsigned c = 0; c < 3; c++) begin
                    sum_q[i][c] <= '0;
                end
            end
        end else begin
            c_valid <= 1'b0;
            done    <= 1'b0;
            case (state)
                ACCUM: begin
                    if (pix_valid && pix_ready) begin
                        if (cnt_q[pix_index] == '1) begin
                            ovf <= 1'b1;
                        end else begin
                            cnt_q[pix_index] <= cnt_q[pix_index] + CNT_W'(1);
                            for (int unsigned c = 0; c < 3; c++) begin
                                sum_q[pix_index][c] <= sum_q[pix_index][c]
                                                       + SUM_W'(pix_in[8*c +: 8]);
                            end
                        end
                    end
                    if (frame_end) begin
                        k         <= '0;
                        state     <= LOAD;
                        busy      <= 1'b1;
                        pix_ready <= 1'b0;
                    end
                end

                LOAD: begin
                    for (int unsigned c = 0; c < 3; c++) begin
                        dvd[c] <= sum_q[k][c];
                        rem[c] <= '0;
                        quo[c] <= '0;
                    end
                    dvs      <= cnt_q[k];
                    zero_div <= (cnt_q[k] == '0);
                    it_cnt   <= ITW'(SUM_W - 1);
                    state    <= ITER;
                end

                ITER: begin
                    for (int unsigned c = 0; c < 3; c++) begin
                        dvd[c] <= {dvd[c][SUM_W-2:0], 1'b0};
                        rem[c] <= rem_nx[c];
                        quo[c] <= quo_nx[c][6:0];
                    end
                    // The final quotient bit is folded straight into c_out so that
                    // c_valid is already registered high during the EMIT cycle.
                    if (it_cnt == '0) begin
                        state   <= EMIT;
                        c_valid <= 1'b1;
                        c_idx   <= k;
                        c_empty <= zero_div;
                        c_out   <= zero_div ? '0 : {quo_nx[2], quo_nx[1], quo_nx[0]};
                        done    <= (k == 3'd7);
                    end else begin
                        it_cnt <= it_cnt - ITW'(1);
                    end
                end

                EMIT: begin
                    if (k == 3'd7) begin
                        state     <= ACCUM;
                        busy      <= 1'b0;
                        pix_ready <= 1'b1;
                        for (int unsigned i = 0; i < 8; i++) begin
                            cnt_q[i] <= '0;
                            for (int unsigned c = 0; c < 3; c++) begin
                                sum_q[i][c] <= '0;
                            end
                        end
                    end else begin
                        k     <= k + 3'd1;
                        state <= LOAD;
                    end
                end

                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Self-checking bench for kmeans_centroid_update: table-driven two-pixel frames
// with a scoreboard of expected centroid emissions, plus hand-written sequences
// for reset, busy lockout, clear and count saturation.
module tb_kmeans_centroid_update;

    localparam int SW = 20;       // SUM_W for CNT_W = 12
    localparam int P  = SW + 2;   // cycles per cluster
    localparam int P2 = 4 + 8 + 2; // cycles per cluster for CNT_W = 4

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear, pix_valid, frame_end;
    logic [23:0] pix_in;
    logic [2:0]  pix_index;
    logic        pix_ready, c_valid, c_empty, busy, done, ovf;
    logic [2:0]  c_idx;
    logic [23:0] c_out;

    logic        clear2, pix_valid2, frame_end2;
    logic [23:0] pix_in2;
    logic [2:0]  pix_index2;
    logic        pix_ready2, c_valid2, c_empty2, busy2, done2, ovf2;
    logic [2:0]  c_idx2;
    logic [23:0] c_out2;

    kmeans_centroid_update #(.CNT_W(12)) dut (
        .clk(clk), .rst(rst_n), .clear(clear), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_in(pix_in), .pix_index(pix_index),
        .frame_end(frame_end), .c_valid(c_valid), .c_idx(c_idx), .c_out(c_out),
        .c_empty(c_empty), .busy(busy), .done(done), .ovf(ovf)
    );

    kmeans_centroid_update #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst_n), .clear(clear2), .pix_valid(pix_valid2),
        .pix_ready(pix_ready2), .pix_in(pix_in2), .pix_index(pix_index2),
        .frame_end(frame_end2), .c_valid(c_valid2), .c_idx(c_idx2), .c_out(c_out2),
        .c_empty(c_empty2), .busy(busy2), .done(done2), .ovf(ovf2)
    );

    initial forever #5 clk = ~clk;

    int edges   = 0;
    int fe_edge = 0;
    int n_cmp   = 0;
    int n_bad   = 0;

    always @(posedge clk) edges++;

    typedef struct {
        logic [2:0]  idx;
        logic [23:0] out;
        logic        empty;
        logic        dn;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        logic [2:0]  idx;
        logic        fe_last;
        logic [23:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Scoreboard consumer: every c_valid must match the head of the queue
    always @(negedge clk) begin
        if (c_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_cvalid: got idx=%0d out=%06h, want no output", c_idx, c_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (c_idx !== e.idx || c_out !== e.out || c_empty !== e.empty ||
                    done !== e.dn || (edges - fe_edge) != e.cyc) begin
                    n_bad++;
                    $display("FAIL centroid: got idx=%0d out=%06h empty=%0b done=%0b cyc=%0d, want idx=%0d out=%06h empty=%0b done=%0b cyc=%0d",
                             c_idx, c_out, c_empty, done, edges - fe_edge,
                             e.idx, e.out, e.empty, e.dn, e.cyc);
                end
            end
        end else if (done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_done: got done=1 without c_valid, want 0");
        end
    end

    task automatic push_frame(input int nz, input logic [23:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.idx   = 3'(i);
            e.out   = (i == nz) ? v : 24'h0;
            e.empty = (i == nz) ? 1'b0 : 1'b1;
            e.dn    = (i == 7);
            e.cyc   = i * P + SW + 1;
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; inputs are sampled by the next rising edge
    task automatic drive(input logic v, input logic [23:0] p, input logic [2:0] i, input logic fe);
        pix_valid = v;
        pix_in    = p;
        pix_index = i;
        frame_end = fe;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        frame_end = 1'b0;
        if (fe) fe_edge = edges;
    endtask

    task automatic wait_until(input int c);
        int g = 0;
        while ((edges - fe_edge) < c && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        chk("reach_cycle", edges - fe_edge, c);
    endtask

    task automatic wait_sb();
        int g = 0;
        while (sb.size() != 0 && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic finish_frame_checks();
        chk("ready_cycle", edges - fe_edge, 8 * P);
        chk("ready_after", pix_ready, 1);
        chk("busy_after", busy, 0);
    endtask

    task automatic run_single(input logic [2:0] idx, input logic [23:0] p);
        push_frame(int'(idx), p, 8);
        drive(1'b1, p, idx, 1'b0);
        drive(1'b0, 24'h0, 3'd0, 1'b1);
        wait_sb();
        finish_frame_checks();
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0; pix_valid = 1'b0; frame_end = 1'b0; pix_in = '0; pix_index = '0;
        clear2 = 1'b0; pix_valid2 = 1'b0; frame_end2 = 1'b0; pix_in2 = '0; pix_index2 = '0;

        vecs[0] = '{p0: 24'h0A1420, p1: 24'h0C1622, idx: 3'd2, fe_last: 1'b0, exp_out: 24'h0B1521};
        vecs[1] = '{p0: 24'h000001, p1: 24'h000002, idx: 3'd5, fe_last: 1'b1, exp_out: 24'h000001};
        vecs[2] = '{p0: 24'hFF00FF, p1: 24'h00FF01, idx: 3'd7, fe_last: 1'b1, exp_out: 24'h7F7F80};
        vecs[3] = '{p0: 24'h102030, p1: 24'h102030, idx: 3'd0, fe_last: 1'b0, exp_out: 24'h102030};
        vecs[4] = '{p0: 24'h010203, p1: 24'h020304, idx: 3'd4, fe_last: 1'b1, exp_out: 24'h010203};

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_c_valid", c_valid, 0);
        chk("rst_c_idx", c_idx, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_c_empty", c_empty, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);

        // Table-driven two-pixel frames
        for (int v = 0; v < 5; v++) begin
            push_frame(int'(vecs[v].idx), vecs[v].exp_out, 8);
            drive(1'b1, vecs[v].p0, vecs[v].idx, 1'b0);
            if (vecs[v].fe_last) begin
                drive(1'b1, vecs[v].p1, vecs[v].idx, 1'b1);
            end else begin
                drive(1'b1, vecs[v].p1, vecs[v].idx, 1'b0);
                drive(1'b0, 24'h0, 3'd0, 1'b1);
            end
            wait_sb();
            finish_frame_checks();
        end

        // Busy lockout: pixels offered in cycles 10..30 must be refused
        push_frame(0, 24'h102030, 8);
        drive(1'b1, 24'h102030, 3'd0, 1'b0);
        drive(1'b0, 24'h0, 3'd0, 1'b1);
        wait_until(10);
        pix_valid = 1'b1; pix_in = 24'hFFFFFF; pix_index = 3'd0;
        for (int c = 10; c <= 30; c++) begin
            chk("lockout_ready", pix_ready, 0);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        chk("lockout_busy", busy, 1);
        wait_sb();
        finish_frame_checks();
        run_single(3'd0, 24'h204060);

        // Asynchronous reset mid-ITER of cluster 3
        push_frame(3, 24'h445566, 3);
        drive(1'b1, 24'h445566, 3'd3, 1'b0);
        drive(1'b0, 24'h0, 3'd0, 1'b1);
        wait_until(75);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pix_ready", pix_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_c_valid", c_valid, 0);
        chk("arst_c_idx", c_idx, 0);
        chk("arst_c_out", c_out, 0);
        chk("arst_c_empty", c_empty, 0);
        chk("arst_done", done, 0);
        chk("arst_sb", sb.size(), 0);
        sb.delete();
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (200) begin @(posedge clk); #1; end
        run_single(3'd0, 24'h102030);

        // clear in cycle 40: only cluster 0 is emitted
        push_frame(0, 24'h112233, 1);
        drive(1'b1, 24'h112233, 3'd0, 1'b0);
        drive(1'b0, 24'h0, 3'd0, 1'b1);
        wait_until(40);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_busy", busy, 0);
        chk("clear_ready", pix_ready, 1);
        repeat (200) begin @(posedge clk); #1; end
        chk("clear_sb", sb.size(), 0);
        sb.delete();
        run_single(3'd1, 24'h808080);
        chk("no_ovf", ovf, 0);

        // Saturation on the CNT_W = 4 instance
        begin
            int fe2, g;
            for (int i = 1; i <= 17; i++) begin
                pix_valid2 = 1'b1; pix_in2 = 24'hFFFFFF; pix_index2 = 3'd0;
                @(posedge clk); #1;
                if (i == 15) chk("sat_ovf_15", ovf2, 0);
                if (i == 16) chk("sat_ovf_16", ovf2, 1);
            end
            pix_valid2 = 1'b0;
            frame_end2 = 1'b1;
            @(posedge clk); #1;
            frame_end2 = 1'b0;
            fe2 = edges;
            g = 0;
            while (!c_valid2 && g < 200) begin @(negedge clk); g++; end
            chk("sat_c_valid", c_valid2, 1);
            chk("sat_idx", c_idx2, 0);
            chk("sat_out", c_out2, 24'hFFFFFF);
            chk("sat_empty", c_empty2, 0);
            chk("sat_cyc", edges - fe2, SW - 8 + 1);
            g = 0;
            while (!done2 && g < 200) begin @(negedge clk); g++; end
            chk("sat_done_idx", c_idx2, 7);
            chk("sat_done_cyc", edges - fe2, 7 * P2 + 13);
            chk("sat_ovf_sticky", ovf2, 1);
            @(posedge clk); #1;
            clear2 = 1'b1;
            @(posedge clk); #1;
            clear2 = 1'b0;
            chk("sat_ovf_cleared", ovf2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
